// File: rtl/onehot_step_decoder_pkg.sv
// rtl/onehot_step_decoder_pkg.sv - shared state encoding and one-hot helper for the step decoder
package onehot_step_pkg;

  typedef enum logic [1:0] {
    OFF = 2'd0,
    ON  = 2'd1,
    RUN = 2'd2
  } state_t;

  // Widest one-hot bus the helper can produce; callers narrow it to N_OUT.
  localparam int MAX_OUT = 64;

  function automatic logic [MAX_OUT-1:0] onehot_of(input logic [31:0] idx);
    logic [MAX_OUT-1:0] v;
    v = '0;
    if (idx < 32'(MAX_OUT)) v[idx[5:0]] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/onehot_step_decoder_if.sv
// rtl/onehot_step_decoder_if.sv - load/step control and one-hot output bundle
interface onehot_step_decoder_if #(
  parameter int N_OUT = 5,
  parameter int IDX_W = $clog2(N_OUT)
);
  logic             clear;
  logic             load_valid;
  logic             load_ready;
  logic [IDX_W-1:0] load_idx;
  logic             step_en;
  logic             step_dir;
  logic [N_OUT-1:0] dec_out;
  logic [IDX_W-1:0] idx_out;
  logic             out_valid;
  logic             err_range;
  logic             at_end;

  modport master (
    output clear, load_valid, load_idx, step_en, step_dir,
    input  load_ready, dec_out, idx_out, out_valid, err_range, at_end
  );

  modport slave (
    input  clear, load_valid, load_idx, step_en, step_dir,
    output load_ready, dec_out, idx_out, out_valid, err_range, at_end
  );
endinterface

// File: rtl/onehot_step_decoder_tick_gen.sv
// rtl/onehot_step_decoder_tick_gen.sv - divide-by-TICK_DIV step pulse generator
module tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;

  assign tick = en & ~clr & (cnt_q == LAST);

  // Counter sits at zero whenever it is not enabled, so each RUN entry starts a full period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr || !en || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
endmodule

// File: rtl/onehot_step_decoder.sv
// rtl/onehot_step_decoder.sv - registered binary-to-one-hot decoder with load and walking-bit mode
module onehot_step_decoder
  import onehot_step_pkg::*;
#(
  parameter int N_OUT    = 5,
  parameter int IDX_W    = $clog2(N_OUT),
  parameter int TICK_DIV = 4,
  parameter int WRAP     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  onehot_step_decoder_if.slave  bus
);
  localparam logic [IDX_W:0] N_EXT    = (IDX_W + 1)'(N_OUT);
  localparam logic [IDX_W:0] LAST_EXT = (IDX_W + 1)'(N_OUT - 1);
  localparam bit             SAT      = (WRAP == 0);

  state_t           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [N_OUT-1:0] dec_q;
  logic             valid_q;
  logic             err_q;

  logic             load_acc;
  logic             idx_ok;
  logic             run_en;
  logic             tick;
  logic [IDX_W:0]   idx_ext;
  logic [IDX_W:0]   nxt_ext;
  logic [N_OUT-1:0] load_oh;
  logic [N_OUT-1:0] step_oh;

  assign load_acc = bus.load_valid & ~bus.clear;
  assign idx_ok   = {1'b0, bus.load_idx} < N_EXT;
  assign idx_ext  = {1'b0, idx_q};
  assign run_en   = (state_q == RUN) & bus.step_en;
  assign load_oh  = N_OUT'(onehot_of(32'(bus.load_idx)));
  assign step_oh  = N_OUT'(onehot_of(32'(nxt_ext)));

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (bus.clear | load_acc),
    .en   (run_en),
    .tick (tick)
  );

  // Next index in the current direction; the extra bit keeps the limit compares unsigned and overflow-free.
  always_comb begin
    nxt_ext = idx_ext;
    if (bus.step_dir) begin
      if (idx_ext == '0) nxt_ext = SAT ? '0 : LAST_EXT;
      else               nxt_ext = idx_ext - 1'b1;
    end else begin
      if (idx_ext == LAST_EXT) nxt_ext = SAT ? LAST_EXT : '0;
      else                     nxt_ext = idx_ext + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OFF;
      idx_q   <= '0;
      dec_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (bus.clear) begin
        state_q <= OFF;
        dec_q   <= '0;
        valid_q <= 1'b0;
      end else if (load_acc) begin
        if (idx_ok) begin
          idx_q   <= bus.load_idx;
          dec_q   <= load_oh;
          valid_q <= 1'b1;
          state_q <= bus.step_en ? RUN : ON;
        end else begin
          dec_q   <= '0;
          valid_q <= 1'b0;
          err_q   <= 1'b1;
          state_q <= OFF;
        end
      end else begin
        case (state_q)
          ON: if (bus.step_en) state_q <= RUN;
          RUN: begin
            if (!bus.step_en) begin
              state_q <= ON;
            end else if (tick) begin
              idx_q <= nxt_ext[IDX_W-1:0];
              dec_q <= step_oh;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.load_ready = ~bus.clear;
  assign bus.dec_out    = dec_q;
  assign bus.idx_out    = idx_q;
  assign bus.out_valid  = valid_q;
  assign bus.err_range  = err_q;
  assign bus.at_end     = SAT & valid_q &
                          (bus.step_dir ? (idx_ext == '0) : (idx_ext == LAST_EXT));
endmodule

// File: tb/tb_onehot_step_decoder.sv
// tb/tb_onehot_step_decoder.sv - directed bench for onehot_step_decoder, wrap and saturate builds side by side
module tb_onehot_step_decoder;
  localparam int N  = 5;
  localparam int IW = 3;
  localparam int TD = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0, load_valid = 1'b0, step_en = 1'b0, step_dir = 1'b0;
  logic [IW-1:0] load_idx = '0;

  int  n_vec  = 0;
  int  n_fail = 0;
  bit  done   = 1'b0;

  always #5 clk = ~clk;

  onehot_step_decoder_if #(.N_OUT(N), .IDX_W(IW)) if_w ();
  onehot_step_decoder_if #(.N_OUT(N), .IDX_W(IW)) if_s ();

  assign if_w.clear = clear;      assign if_s.clear = clear;
  assign if_w.load_valid = load_valid; assign if_s.load_valid = load_valid;
  assign if_w.load_idx = load_idx;  assign if_s.load_idx = load_idx;
  assign if_w.step_en = step_en;    assign if_s.step_en = step_en;
  assign if_w.step_dir = step_dir;  assign if_s.step_dir = step_dir;

  onehot_step_decoder #(.N_OUT(N), .IDX_W(IW), .TICK_DIV(TD), .WRAP(1)) u_wrap (
    .clk(clk), .rst_n(rst_n), .bus(if_w));
  onehot_step_decoder #(.N_OUT(N), .IDX_W(IW), .TICK_DIV(TD), .WRAP(0)) u_sat (
    .clk(clk), .rst_n(rst_n), .bus(if_s));

  // Model: index 0 is the wrapping build, index 1 the saturating one.
  bit wr [2] = '{1'b1, 1'b0};
  bit m_valid [2];
  bit m_run [2];
  bit m_err [2];
  int m_idx [2];
  int m_age [2];

  function automatic int move(int i, bit dir, bit wrap);
    if (wrap) return dir ? (i + N - 1) % N : (i + 1) % N;
    return dir ? ((i > 0) ? i - 1 : 0) : ((i < N - 1) ? i + 1 : N - 1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      m_err[k] = 1'b0;
      if (!rst_n) begin
        m_valid[k] = 1'b0; m_run[k] = 1'b0; m_idx[k] = 0; m_age[k] = 0;
      end else if (clear) begin
        m_valid[k] = 1'b0; m_run[k] = 1'b0; m_age[k] = 0;
      end else if (load_valid) begin
        m_age[k] = 0;
        if (int'(load_idx) < N) begin
          m_idx[k] = int'(load_idx); m_valid[k] = 1'b1; m_run[k] = step_en;
        end else begin
          m_valid[k] = 1'b0; m_run[k] = 1'b0; m_err[k] = 1'b1;
        end
      end else if (m_valid[k]) begin
        if (!step_en) begin
          m_run[k] = 1'b0; m_age[k] = 0;
        end else if (!m_run[k]) begin
          m_run[k] = 1'b1; m_age[k] = 0;
        end else begin
          m_age[k]++;
          if (m_age[k] == TD) begin
            m_age[k] = 0;
            m_idx[k] = move(m_idx[k], step_dir, wr[k]);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp(input int k, input logic [N-1:0] dec, input logic [IW-1:0] idx,
                     input logic ov, input logic er, input logic ae, input logic lr);
    logic [31:0] e_dec;
    bit e_ae;
    e_dec = m_valid[k] ? (32'd1 << m_idx[k]) : 32'd0;
    e_ae  = !wr[k] && m_valid[k] && (step_dir ? (m_idx[k] == 0) : (m_idx[k] == N - 1));
    chk($sformatf("dec_out[%0d]", k), 32'(dec), e_dec);
    chk($sformatf("idx_out[%0d]", k), 32'(idx), 32'(m_idx[k]));
    chk($sformatf("out_valid[%0d]", k), 32'(ov), 32'(m_valid[k]));
    chk($sformatf("err_range[%0d]", k), 32'(er), 32'(m_err[k]));
    chk($sformatf("at_end[%0d]", k), 32'(ae), 32'(e_ae));
    chk($sformatf("load_ready[%0d]", k), 32'(lr), 32'(!clear));
    chk($sformatf("onehot0[%0d]", k), 32'($onehot0(dec)), 32'd1);
  endtask

  always @(negedge clk) begin
    if (!done) begin
      cmp(0, if_w.dec_out, if_w.idx_out, if_w.out_valid, if_w.err_range, if_w.at_end, if_w.load_ready);
      cmp(1, if_s.dec_out, if_s.idx_out, if_s.out_valid, if_s.err_range, if_s.at_end, if_s.load_ready);
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    cyc(2);
    rst_n = 1'b1;
    cyc();
    chk("rst dec", 32'(if_w.dec_out), 32'd0);
    chk("rst valid", 32'(if_w.out_valid), 32'd0);
    chk("rst idx", 32'(if_w.idx_out), 32'd0);

    load_valid = 1'b1; load_idx = 3'd3; cyc(); load_valid = 1'b0;
    chk("load3 dec", 32'(if_w.dec_out), 32'b01000);
    chk("load3 idx", 32'(if_w.idx_out), 32'd3);
    chk("load3 valid", 32'(if_w.out_valid), 32'd1);
    chk("load3 err", 32'(if_w.err_range), 32'd0);

    load_valid = 1'b1; load_idx = 3'd5; cyc(); load_valid = 1'b0;
    chk("bad5 dec", 32'(if_w.dec_out), 32'd0);
    chk("bad5 err", 32'(if_w.err_range), 32'd1);
    chk("bad5 idx", 32'(if_w.idx_out), 32'd3);
    cyc();
    chk("bad5 err drop", 32'(if_w.err_range), 32'd0);

    load_valid = 1'b1; load_idx = 3'd4; step_en = 1'b1; step_dir = 1'b0; cyc(); load_valid = 1'b0;
    chk("wrap start", 32'(if_w.dec_out), 32'b10000);
    chk("sat top at_end", 32'(if_s.at_end), 32'd1);
    cyc(3);
    chk("wrap hold", 32'(if_w.dec_out), 32'b10000);
    cyc();
    chk("wrap step1", 32'(if_w.dec_out), 32'b00001);
    cyc(4);
    chk("wrap step2", 32'(if_w.dec_out), 32'b00010);
    chk("sat top held", 32'(if_s.dec_out), 32'b10000);

    load_valid = 1'b1; load_idx = 3'd1; step_dir = 1'b1; cyc(); load_valid = 1'b0;
    chk("sat load1 at_end", 32'(if_s.at_end), 32'd0);
    cyc(4);
    chk("sat bottom dec", 32'(if_s.dec_out), 32'b00001);
    chk("sat bottom at_end", 32'(if_s.at_end), 32'd1);
    cyc(8);
    chk("sat bottom held", 32'(if_s.dec_out), 32'b00001);
    step_dir = 1'b0; #1;
    chk("sat reverse at_end", 32'(if_s.at_end), 32'd0);
    cyc(3);
    chk("sat reverse wait", 32'(if_s.dec_out), 32'b00001);
    cyc();
    chk("sat reverse step", 32'(if_s.dec_out), 32'b00010);

    clear = 1'b1; load_valid = 1'b1; load_idx = 3'd2; #1;
    chk("clear load_ready", 32'(if_w.load_ready), 32'd0);
    cyc(); clear = 1'b0; load_valid = 1'b0;
    chk("clear dec", 32'(if_w.dec_out), 32'd0);
    chk("clear valid", 32'(if_w.out_valid), 32'd0);

    load_valid = 1'b1; load_idx = 3'd2; cyc(); load_valid = 1'b0;
    cyc(3);
    load_valid = 1'b1; load_idx = 3'd2; cyc(); load_valid = 1'b0;
    chk("tick vs load", 32'(if_w.dec_out), 32'b00100);
    cyc(3);
    chk("post load hold", 32'(if_w.dec_out), 32'b00100);
    cyc();
    chk("post load step", 32'(if_w.dec_out), 32'b01000);

    cyc(2);
    #1 rst_n = 1'b0;
    #1;
    chk("async dec w", 32'(if_w.dec_out), 32'd0);
    chk("async valid s", 32'(if_s.out_valid), 32'd0);
    chk("async idx w", 32'(if_w.idx_out), 32'd0);
    cyc();
    rst_n = 1'b1;
    step_en = 1'b0; step_dir = 1'b1; load_valid = 1'b1; load_idx = 3'd0; cyc(); load_valid = 1'b0;
    chk("sat idx0 at_end", 32'(if_s.at_end), 32'd1);
    chk("wrap idx0 at_end", 32'(if_w.at_end), 32'd0);
    load_valid = 1'b1; load_idx = 3'd7; cyc(); load_valid = 1'b0;
    chk("bad7 err", 32'(if_s.err_range), 32'd1);
    chk("bad7 idx", 32'(if_s.idx_out), 32'd0);
    cyc(3);

    done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/onehot_step_decoder.md
Name: onehot_step_decoder

Overview:
Registered, parametrised binary-to-one-hot decoder with load handshake and an auto-step (walking-bit) mode. Drives LED/segment-select style one-hot buses of N_OUT lines. Out-of-range indices blank the output and flag an error. A programmable tick divider advances the hot bit up or down, with wrap or saturate at the ends.

Parameters:
N_OUT, 5, number of one-hot output lines (>=2)
IDX_W, $clog2(N_OUT) (3), width of index buses
TICK_DIV, 4, clock cycles per auto-step (>=1)
WRAP, 1, 1 = wrap at ends; 0 = saturate at ends

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
clear  in  1  synchronous blank; highest priority
load_valid  in  1  load request
load_ready  out  1  load accepted when high; combinational, = ~clear
load_idx  in  IDX_W  index to decode
step_en  in  1  enable auto-stepping
step_dir  in  1  0 = increment index, 1 = decrement index
dec_out  out  N_OUT  registered one-hot output, or all-zero when blank
idx_out  out  IDX_W  current index
out_valid  out  1  dec_out holds a hot bit
err_range  out  1  one-cycle pulse: load_idx >= N_OUT was accepted
at_end  out  1  high while WRAP=0 and index is at the limit in step_dir

Behaviour:
- Reset (async assert, sync release):
  - dec_out=0, idx_out=0, out_valid=0, err_range=0, at_end=0.
  - Tick counter=0, state OFF.
- States:
  - OFF: blank.
  - ON: hot bit held.
  - RUN: hot bit stepping; entered from ON when step_en=1.
- Per-cycle priority is clear > load > step.
  - clear=1: go to OFF, blank, counter=0. Any load is not accepted because load_ready=0.
  - Load accept = load_valid & load_ready.
    - Valid index (load_idx < N_OUT): idx_out <= load_idx, dec_out <= 1<<load_idx, out_valid <= 1. Latency 1 cycle.
    - After a valid load, go to RUN if step_en else ON. Counter resets to 0.
    - Invalid index (load_idx >= N_OUT): blank, out_valid=0, err_range=1 for exactly that next cycle, go to OFF. idx_out is unchanged.
- Tick counter:
  - Counts 0..TICK_DIV-1 only in RUN.
  - A step fires in the cycle the counter equals TICK_DIV-1; the counter then returns to 0.
  - The first step therefore occurs TICK_DIV cycles after entering RUN.
  - step_en=0 in RUN: go to ON and reset the counter to 0.
- Step:
  - idx += 1 (step_dir=0) or idx -= 1 (step_dir=1).
  - dec_out updates in the same registered cycle as idx_out.
- Ends:
  - WRAP=1: N_OUT-1 -> 0 when incrementing; 0 -> N_OUT-1 when decrementing.
  - WRAP=0: index holds at the limit and at_end=1. Reversing step_dir drops at_end, and the next tick moves away from the limit.
- A load arriving in the same cycle as a tick wins; the tick is discarded.
- step_dir change mid-count takes effect at the next tick; the counter is not reset.
- Invariant every cycle: dec_out == (out_valid ? 1<<idx_out : 0), with $onehot0(dec_out).
- Arithmetic:
  - Index math is done in IDX_W+1 bits. Comparison against N_OUT is unsigned.
  - No index >= N_OUT ever reaches idx_out.
- Reset asserted mid-RUN clears everything immediately, regardless of clk.

Decomposition:
- Package onehot_step_pkg holds:
  - state_t enum {OFF, ON, RUN};
  - a function onehot_of(idx) returning N_OUT bits.
- Sub-module tick_gen(TICK_DIV) holds the counter and tick pulse. Inputs: clk, rst_n, clr, en. Output: tick.

Test Plan:
- Reset then load_idx=3 (N_OUT=5) -> next cycle dec_out=5'b01000, idx_out=3, out_valid=1, err_range=0.
- load_idx=5 -> dec_out=0, out_valid=0, err_range pulses exactly 1 cycle, idx_out retains its previous value.
- load 4, step_en=1, dir=0, TICK_DIV=4, WRAP=1 -> dec_out 10000, then 4 cycles later 00001, then 4 cycles later 00010.
- WRAP=0, load 1, dir=1 -> after 4 cycles 00001 with at_end=1, held indefinitely; set dir=0 -> at_end=0, 4 cycles later 00010.
- clear and load_valid asserted together in RUN -> load_ready=0, next cycle dec_out=0, out_valid=0, counter=0.
- Load coincident with tick (load 2 at tick cycle) -> dec_out=00100 and no step; the next step occurs 4 cycles later. Async rst_n drop mid-RUN -> outputs zero before the next clk edge.
